// File: rtl/rice_partition_sequencer.sv
// Rice partition sequencer: walks the partitions of one block, fetches each Rice
// parameter and turns residuals into registered writer commands (param, sample, flush).
module rice_partition_sequencer #(
  parameter int unsigned MAX_PORDER = 8
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [15:0]        iBlockSize,
  input  logic [3:0]         iPartitionOrder,
  input  logic [5:0]         iWarmup,
  input  logic               iParamValid,
  input  logic [3:0]         iRiceParam,
  output logic               oParamReady,
  input  logic               iResidualValid,
  input  logic signed [15:0] iResidual,
  output logic               oResidualReady,
  output logic               oEnable,
  output logic               oChangeParam,
  output logic               oFlush,
  output logic [15:0]        oTotal,
  output logic [15:0]        oUpper,
  output logic [15:0]        oLower,
  output logic [3:0]         oRiceParam,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StGetParam = 3'd1;
  localparam logic [2:0] StEmit     = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StDrain    = 3'd4;
  localparam logic [2:0] StFlush    = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [3:0]  porder_q, porder_d;
  logic [15:0] len_q, len_d;
  logic [15:0] part_q, part_d;
  logic [15:0] remaining_q, remaining_d;
  logic [3:0]  k_q, k_d;

  logic        enable_q, enable_d;
  logic        change_q, change_d;
  logic        flush_q, flush_d;
  logic [15:0] total_q, total_d;
  logic [15:0] upper_q, upper_d;
  logic [15:0] lower_q, lower_d;
  logic [3:0]  rice_q, rice_d;
  logic        error_q, error_d;

  logic [15:0] start_len;
  logic [15:0] part_max;
  logic        sample_fire;
  logic [15:0] zz;
  logic [15:0] zz_upper;
  logic [15:0] zz_lower;
  logic [16:0] zz_total;

  assign start_len   = iBlockSize >> iPartitionOrder;
  assign part_max    = (16'd1 << porder_q) - 16'd1;
  assign sample_fire = (state_q == StData) && iResidualValid && (remaining_q != 16'd0);

  // Zigzag fold then split into unary quotient and binary remainder with a leading 1.
  assign zz       = {iResidual[14:0], 1'b0} ^ {16{iResidual[15]}};
  assign zz_upper = zz >> k_q;
  assign zz_lower = (16'd1 << k_q) | (zz & ((16'd1 << k_q) - 16'd1));
  assign zz_total = {1'b0, zz_upper} + 17'(k_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    porder_d    = porder_q;
    len_d       = len_q;
    part_d      = part_q;
    remaining_d = remaining_q;
    k_d         = k_q;
    enable_d    = 1'b0;
    change_d    = 1'b0;
    flush_d     = 1'b0;
    total_d     = total_q;
    upper_d     = upper_q;
    lower_d     = lower_q;
    rice_d      = rice_q;
    error_d     = error_q;

    case (state_q)
      StIdle: begin
        if (iStart) begin
          error_d     = 1'b0;
          porder_d    = iPartitionOrder;
          len_d       = start_len;
          part_d      = 16'd0;
          remaining_d = start_len - 16'(iWarmup);
          if ((32'(iPartitionOrder) > MAX_PORDER) || (start_len == 16'd0) ||
              (16'(iWarmup) > start_len)) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StGetParam;
          end
        end
      end
      StGetParam: begin
        if (iParamValid) begin
          k_d      = iRiceParam;
          enable_d = 1'b1;
          if (iRiceParam == 4'd15) begin
            error_d = 1'b1;
            flush_d = 1'b1;
            state_d = StFlush;
          end else begin
            change_d = 1'b1;
            rice_d   = iRiceParam;
            state_d  = StEmit;
          end
        end
      end
      StEmit: begin
        if (remaining_q != 16'd0) begin
          state_d = StData;
        end else if (part_q != part_max) begin
          part_d      = part_q + 16'd1;
          remaining_d = len_q;
          state_d     = StGetParam;
        end else begin
          state_d = StDrain;
        end
      end
      StData: begin
        if (sample_fire) begin
          remaining_d = remaining_q - 16'd1;
          // An unrepresentable code length drops the command but the sample still counts.
          if (zz_total[16]) begin
            error_d = 1'b1;
          end else begin
            enable_d = 1'b1;
            total_d  = zz_total[15:0];
            upper_d  = zz_upper;
            lower_d  = zz_lower;
          end
          if (remaining_q == 16'd1) begin
            if (part_q != part_max) begin
              part_d      = part_q + 16'd1;
              remaining_d = len_q;
              state_d     = StGetParam;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        enable_d = 1'b1;
        flush_d  = 1'b1;
        state_d  = StFlush;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= StIdle;
      porder_q    <= 4'd0;
      len_q       <= 16'd0;
      part_q      <= 16'd0;
      remaining_q <= 16'd0;
      k_q         <= 4'd0;
      enable_q    <= 1'b0;
      change_q    <= 1'b0;
      flush_q     <= 1'b0;
      total_q     <= 16'd0;
      upper_q     <= 16'd0;
      lower_q     <= 16'd0;
      rice_q      <= 4'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      porder_q    <= porder_d;
      len_q       <= len_d;
      part_q      <= part_d;
      remaining_q <= remaining_d;
      k_q         <= k_d;
      enable_q    <= enable_d;
      change_q    <= change_d;
      flush_q     <= flush_d;
      total_q     <= total_d;
      upper_q     <= upper_d;
      lower_q     <= lower_d;
      rice_q      <= rice_d;
      error_q     <= error_d;
    end
  end

  assign oParamReady    = (state_q == StGetParam);
  assign oResidualReady = (state_q == StData) && (remaining_q != 16'd0);
  assign oEnable        = enable_q;
  assign oChangeParam   = change_q;
  assign oFlush         = flush_q;
  assign oTotal         = total_q;
  assign oUpper         = upper_q;
  assign oLower         = lower_q;
  assign oRiceParam     = rice_q;
  assign oBusy          = (state_q != StIdle);
  assign oDone          = (state_q == StDone);
  assign oError         = error_q;

endmodule

// File: tb/tb_rice_partition_sequencer.sv
// Scoreboard bench for rice_partition_sequencer: expected writer commands are queued as
// stimulus is driven and matched against every oEnable cycle.
module tb_rice_partition_sequencer;

  logic               iClock = 1'b0;
  logic               iReset_n = 1'b0;
  logic               iStart = 1'b0;
  logic [15:0]        iBlockSize = '0;
  logic [3:0]         iPartitionOrder = '0;
  logic [5:0]         iWarmup = '0;
  logic               iParamValid = 1'b0;
  logic [3:0]         iRiceParam = '0;
  logic               oParamReady;
  logic               iResidualValid = 1'b0;
  logic signed [15:0] iResidual = '0;
  logic               oResidualReady;
  logic               oEnable, oChangeParam, oFlush;
  logic [15:0]        oTotal, oUpper, oLower;
  logic [3:0]         oRiceParam;
  logic               oBusy, oDone, oError;

  rice_partition_sequencer #(.MAX_PORDER(8)) dut (
    .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iBlockSize(iBlockSize),
    .iPartitionOrder(iPartitionOrder), .iWarmup(iWarmup), .iParamValid(iParamValid),
    .iRiceParam(iRiceParam), .oParamReady(oParamReady), .iResidualValid(iResidualValid),
    .iResidual(iResidual), .oResidualReady(oResidualReady), .oEnable(oEnable),
    .oChangeParam(oChangeParam), .oFlush(oFlush), .oTotal(oTotal), .oUpper(oUpper),
    .oLower(oLower), .oRiceParam(oRiceParam), .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 iClock = ~iClock;

  // kind: 0 sample, 1 change param, 2 flush
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] t;
    logic [15:0] u;
    logic [15:0] l;
    logic [3:0]  k;
  } exp_t;

  exp_t sb_q[$];
  exp_t fixed_q[$];
  int   k_list[$];
  int   r_list[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] all_outs();
    return {oParamReady, oResidualReady, oEnable, oChangeParam, oFlush, oTotal, oUpper,
            oLower, oRiceParam, oBusy, oDone, oError};
  endfunction

  // Reference coder: returns 1 when the code length does not fit in 16 bits.
  function automatic bit model(input int r, input int k, output exp_t e);
    int u, up, lo, tot;
    u   = (r >= 0) ? 2 * r : -2 * r - 1;
    up  = u / (1 << k);
    lo  = (1 << k) + (u % (1 << k));
    tot = up + k + 1;
    e   = '{kind: 2'd0, t: 16'(tot), u: 16'(up), l: 16'(lo), k: 4'd0};
    return tot > 65535;
  endfunction

  always @(negedge iClock) begin
    if (iReset_n) begin
      if (oEnable) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_cmd", 64'(oEnable), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          case (e.kind)
            2'd1: check_val("change_cmd", {oChangeParam, oFlush, oRiceParam},
                            {1'b1, 1'b0, e.k});
            2'd2: check_val("flush_cmd", {oChangeParam, oFlush}, 2'b01);
            default: check_val("sample_cmd", {oChangeParam, oFlush, oTotal, oUpper, oLower},
                               {2'b00, e.t, e.u, e.l});
          endcase
        end
      end else if (oChangeParam || oFlush) begin
        check_val("stray_ctl", {oChangeParam, oFlush}, 2'b00);
      end
    end
  end

  task automatic start_block(input int bs, input int p, input int w);
    @(negedge iClock);
    iStart = 1'b1;
    iBlockSize = 16'(bs);
    iPartitionOrder = 4'(p);
    iWarmup = 6'(w);
    @(posedge iClock);
    #1 iStart = 1'b0;
  endtask

  task automatic give_param(input int k);
    int n = 0;
    exp_t e;
    @(negedge iClock);
    while (!oParamReady && n < 40) begin
      n++;
      @(negedge iClock);
    end
    check_val("param_ready_seen", 64'(oParamReady), 64'd1);
    e = '{kind: (k == 15) ? 2'd2 : 2'd1, t: '0, u: '0, l: '0, k: 4'(k)};
    sb_q.push_back(e);
    iParamValid = 1'b1;
    iRiceParam = 4'(k);
    @(posedge iClock);
    #1 iParamValid = 1'b0;
  endtask

  task automatic send_residual(input int r, input int k, inout bit exp_err);
    int n = 0;
    exp_t e;
    repeat ($urandom_range(0, 2)) @(posedge iClock);
    @(negedge iClock);
    while (!oResidualReady && n < 40) begin
      n++;
      @(negedge iClock);
    end
    check_val("res_ready_seen", 64'(oResidualReady), 64'd1);
    if (fixed_q.size() > 0) begin
      sb_q.push_back(fixed_q.pop_front());
    end else if (model(r, k, e)) begin
      exp_err = 1'b1;
    end else begin
      sb_q.push_back(e);
    end
    iResidualValid = 1'b1;
    iResidual = 16'(r);
    iStart = 1'($urandom_range(0, 1));  // must be ignored while busy
    @(posedge iClock);
    #1 iResidualValid = 1'b0;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit exp_err);
    int n = 0;
    @(negedge iClock);
    while (!oDone && n < 50) begin
      n++;
      @(negedge iClock);
    end
    check_val({tag, "_done"}, 64'(oDone), 64'd1);
    check_val({tag, "_error"}, 64'(oError), 64'(exp_err));
    check_val({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    @(negedge iClock);
    check_val({tag, "_idle"}, {oBusy, oDone}, 2'b00);
  endtask

  // Consumes k_list / r_list for one full block.
  task automatic run_block(input string tag, input int bs, input int p, input int w);
    int  len = bs >> p;
    bit  exp_err = 1'b0;
    bit  aborted = 1'b0;
    int  k;
    start_block(bs, p, w);
    #1 check_val({tag, "_busy"}, 64'(oBusy), 64'd1);
    for (int part = 0; part < (1 << p); part++) begin
      k = k_list.pop_front();
      give_param(k);
      if (k == 15) begin
        exp_err = 1'b1;
        aborted = 1'b1;
        break;
      end
      for (int i = 0; i < ((part == 0) ? len - w : len); i++) begin
        send_residual(r_list.pop_front(), k, exp_err);
      end
    end
    if (!aborted) sb_q.push_back('{kind: 2'd2, t: '0, u: '0, l: '0, k: '0});
    wait_done(tag, exp_err);
  endtask

  task automatic load_fixed_req028();
    fixed_q.push_back('{kind: 2'd0, t: 16'd3, u: 16'd0, l: 16'd4, k: 4'd0});
    fixed_q.push_back('{kind: 2'd0, t: 16'd3, u: 16'd0, l: 16'd5, k: 4'd0});
    fixed_q.push_back('{kind: 2'd0, t: 16'd5, u: 16'd2, l: 16'd6, k: 4'd0});
    fixed_q.push_back('{kind: 2'd0, t: 16'd4, u: 16'd1, l: 16'd5, k: 4'd0});
    k_list = '{2};
    r_list = '{0, -1, 5, -3};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dummy;
    #12;
    check_val("reset_outputs", 64'(all_outs()), 64'd0);
    @(negedge iClock);
    iReset_n = 1'b1;

    load_fixed_req028();
    run_block("basic", 4, 0, 0);

    k_list = '{3, 1};
    r_list = '{7, -8, 1, 2, -2, 100};
    run_block("two_part", 8, 1, 2);

    k_list = '{4, 2};
    r_list = '{-5, 9};
    run_block("empty_part", 4, 1, 2);

    k_list = '{0};
    r_list = '{-32768};
    run_block("overflow", 1, 0, 0);

    k_list = '{15};
    run_block("k15", 4, 0, 0);

    start_block(16, 9, 0);
    wait_done("bad_porder", 1'b1);

    start_block(16, 0, 17);
    wait_done("bad_warmup", 1'b1);

    // Reset in the middle of the data phase
    start_block(8, 0, 0);
    give_param(3);
    dummy = 1'b0;
    for (int i = 0; i < 3; i++) send_residual(i * 11 - 7, 3, dummy);
    @(negedge iClock);
    #2 iReset_n = 1'b0;
    #1 check_val("midblock_reset", 64'(all_outs()), 64'd0);
    sb_q.delete();
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    iReset_n = 1'b1;

    load_fixed_req028();
    run_block("after_reset", 4, 0, 0);

    for (int b = 0; b < 3; b++) begin
      int p = $urandom_range(0, 2);
      int len = 16 >> p;
      int w = $urandom_range(0, len);
      k_list.delete();
      r_list.delete();
      for (int i = 0; i < (1 << p); i++) k_list.push_back($urandom_range(0, 14));
      for (int i = 0; i < 16 - w; i++) r_list.push_back(int'($signed(16'($urandom))));
      run_block($sformatf("rand%0d", b), 16, p, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rice_partition_sequencer.md
RICE_PARTITION_SEQUENCER -- requirements
Module: rice_partition_sequencer

Interface
REQ-001 SHALL have parameter MAX_PORDER, default 8, meaning largest legal partition order.
REQ-002 SHALL have port iClock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port iReset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iStart  in  1  start-of-block request, sampled only in IDLE.
REQ-005 SHALL have ports iBlockSize  in  16; iPartitionOrder  in  4; iWarmup  in  6  (the warmup input gives samples not Rice-coded).
REQ-006 SHALL have ports iParamValid  in  1; iRiceParam  in  4; oParamReady  out  1  (per-partition parameter handshake).
REQ-007 SHALL have ports iResidualValid  in  1; iResidual  in  16 signed; oResidualReady  out  1.
REQ-008 SHALL have writer-command ports oEnable, oChangeParam, oFlush  out  1 each; oTotal, oUpper, oLower  out  16 each; oRiceParam  out  4.
REQ-009 SHALL have status ports oBusy  out  1; oDone  out  1 (pulse); oError  out  1 (sticky until next accepted iStart).

Function
REQ-010 States SHALL be IDLE, GET_PARAM, EMIT_PARAM, DATA, DRAIN, FLUSH, DONE.
REQ-011 IDLE + iStart: latch inputs; L = iBlockSize >> iPartitionOrder; part = 0; remaining = L - iWarmup; clear oError; go GET_PARAM.
REQ-012 On start, iPartitionOrder > MAX_PORDER, L == 0 or iWarmup > L SHALL set oError and go DONE with no writer commands.
REQ-013 GET_PARAM: oParamReady = 1; on iParamValid latch k; k <= 14 -> EMIT_PARAM; k == 15 -> set oError, go FLUSH.
REQ-014 EMIT_PARAM (one cycle): oEnable = 1, oChangeParam = 1, oRiceParam = k; then DATA if remaining > 0, else next-partition rule (REQ-017).
REQ-015 DATA: oResidualReady = 1 while remaining > 0; each handshake decrements remaining.
REQ-016 Per accepted sample, registered one cycle later: u = (r << 1) XOR {16{r[15]}}; oUpper = u >> k; oLower = (1 << k) | (u mod 2^k); oTotal = oUpper + k + 1; oEnable = 1, oChangeParam = oFlush = 0.
REQ-017 After the last sample of a partition (or immediately if remaining == 0): if part < 2^p - 1, part++, remaining = L, go GET_PARAM; else go DRAIN.
REQ-018 DRAIN (one cycle) SHALL let the final registered sample command issue before FLUSH; no commands issued in DRAIN besides that sample.
REQ-019 FLUSH (one cycle): oEnable = 1, oFlush = 1; then DONE.
REQ-020 DONE (one cycle): oDone = 1; then IDLE.
REQ-021 oTotal SHALL be computed 17 bits wide; if bit 16 set, suppress that sample's oEnable, set oError, still count the sample.
REQ-022 At most one of oChangeParam / oFlush / sample-command SHALL be asserted in any cycle; oEnable SHALL be low in all non-command cycles.
REQ-023 Gaps in iResidualValid SHALL produce no commands; no backpressure from the writer exists.
REQ-024 oBusy = 1 in every state except IDLE; iStart outside IDLE SHALL be ignored.
REQ-025 Command fields (oTotal/oUpper/oLower/oRiceParam) SHALL hold last values when oEnable = 0.

Reset
REQ-026 iReset_n low SHALL immediately force IDLE and all outputs, counters and latched values to 0, discarding any in-flight command.
REQ-027 Reset mid-block SHALL leave no partial state; the next iStart after release SHALL behave as from power-up.

Verification
REQ-028 BlockSize 4, p 0, warmup 0, k 2, residuals 0,-1,5,-3 -> ChangeParam k=2; then (U,L,T) = (0,4,3),(0,5,3),(2,6,5),(1,5,4); Flush; oDone.
REQ-029 BlockSize 8, p 1, warmup 2, k 3 then k 1 -> two ChangeParam; 2 samples then 4 samples; one Flush; oError = 0.
REQ-030 BlockSize 4, p 1, warmup 2 -> partition 0 emits ChangeParam only, immediately GET_PARAM; partition 1 takes 2 samples.
REQ-031 k 0, residual -32768 -> no sample command, oError = 1, block completes with Flush and oDone.
REQ-032 k 15 in GET_PARAM -> oError = 1, Flush next cycle, oDone; iPartitionOrder 9 -> oError, oDone, no commands.
REQ-033 Assert iReset_n low mid-DATA with intermittent iResidualValid -> all outputs 0 same cycle; new block after release encodes correctly.
